bus_stream_writer: RTL and testbench
====================================

Name: bus_stream_writer

Overview:
Data-bus initiator that turns a byte stream into 16-bit memory write transactions. Same data_m protocol as Core's data port, so it can sit beside Core behind MemArbiter or a bus mux. Intended use: UART/JTAG bootloader and host-side memory fill, with no CPU involvement. A command gives the start byte address and byte count; bytes are packed into aligned halfword writes with correct bytesel.

Parameters:
ACK_TIMEOUT, 1024, cycles to wait for data_m_ack before aborting with error; 0 disables the timeout.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle command strobe; sampled only in IDLE
start_addr  input  20  first byte address
length  input  16  byte count (0..65535)
in_valid  input  1  stream byte valid
in_data  input  8  stream byte
in_ready  output  1  byte accepted when in_valid & in_ready
data_m_addr  output  19  halfword address [19:1]
data_m_data_out  output  16  write data
data_m_access  output  1  transaction request
data_m_ack  input  1  one-cycle completion from responder
data_m_wr_en  output  1  always 1 while data_m_access is high, else 0
data_m_bytesel  output  2  [0]=low byte (even addr), [1]=high byte (odd addr)
busy  output  1  high from the cycle after an accepted start until done/error
done  output  1  one-cycle pulse on successful completion
error  output  1  one-cycle pulse on ack timeout

Behaviour:
- Reset (async): state=IDLE. All outputs 0: in_ready, data_m_access, data_m_wr_en, data_m_bytesel, data_m_addr, data_m_data_out, busy, done, error.
- Reset mid-transfer: abort immediately. No further bus activity; remaining bytes not consumed.
- States: IDLE, COLLECT, WRITE, GAP.
- IDLE:
  - start=1 latches addr=start_addr and remaining=length.
  - length=0: pulse done on the next cycle; busy stays 0; no bus access.
  - Otherwise go to COLLECT with busy=1.
  - start while not IDLE is ignored.
- COLLECT:
  - in_ready=1 in this state only.
  - Accepted byte goes to lane addr[0]: lane 0 = data_out[7:0], lane 1 = data_out[15:8]. Set the matching bytesel bit, then addr+=1 and remaining-=1.
  - Go to WRITE when a byte lands in lane 1 (halfword complete) or remaining reaches 0.
  - So a first byte at an odd address writes alone with bytesel=10. A final byte at an even address writes alone with bytesel=01.
  - The unused lane's data is 0.
- WRITE:
  - data_m_access=1 and data_m_wr_en=1.
  - data_m_addr = halfword address of the collected bytes, held stable together with data and bytesel until ack.
  - On data_m_ack: drop access the next cycle; clear bytesel and data.
  - Then: remaining=0 → pulse done, busy=0, IDLE. Otherwise → GAP.
- GAP: exactly one idle cycle with data_m_access=0, then COLLECT. Transactions are never back-to-back.
- Timeout:
  - A counter runs while in WRITE without ack.
  - Reaching ACK_TIMEOUT: drop access, pulse error, busy=0, return to IDLE. done is not pulsed.
  - An ack in the same cycle as expiry takes priority and counts as success.
- Address arithmetic: 20-bit, wraps 0xFFFFF → 0x00000; a halfword write never straddles the wrap.
- in_ready=0 during WRITE/GAP; an upstream byte is held by in_valid.
- Latency: the first bus request is asserted 1 cycle after the completing byte is accepted.
- Only one transaction is ever outstanding.

Test Plan:
1. Aligned: start_addr=0x01000, length=4, bytes 11,22,33,44 → writes (addr 0x00800, data 0x2211, bsel 11), (0x00801, 0x4433, 11); done once; busy low after.
2. Unaligned, odd length: start_addr=0x00003, length=3, bytes AA,BB,CC → (0x00001, 0xAA00, 10), (0x00002, 0xCCBB, 11); done.
3. Final odd byte: start_addr=0x00010, length=1, byte 5A → single write (0x00008, 0x005A, 01); GAP not entered; done.
4. length=0 → done on the next cycle; data_m_access never asserted; busy never asserted.
5. Wrap: start_addr=0xFFFFF, length=2, bytes 01,02 → (0x7FFFF, 0x0100, 10) then (0x00000, 0x0002, 01).
6. Timeout and reset: ACK_TIMEOUT=8 with ack withheld → access drops after 8 cycles, error pulses, busy=0. Repeat with reset asserted during WRITE → all outputs 0 immediately.

Source files
------------

// File: rtl/bus_stream_writer_if.sv
// -----------------------------------------------------------------------------
// bus_stream_writer_if
//   data_m memory bus shared by bus initiators (Core data port, stream writer)
//   and their responders (MemArbiter, bus mux, memory).
//
//   data_m_addr      [18:0]  halfword address (byte address bits [19:1])
//   data_m_data_out  [15:0]  write data
//   data_m_access            transaction request, held until data_m_ack
//   data_m_ack               one-cycle completion from the responder
//   data_m_wr_en             write enable, qualifies data_m_access
//   data_m_bytesel   [1:0]   [0] = low byte (even address), [1] = high byte
// -----------------------------------------------------------------------------
interface bus_stream_writer_if;
    logic [18:0] data_m_addr;
    logic [15:0] data_m_data_out;
    logic        data_m_access;
    logic        data_m_ack;
    logic        data_m_wr_en;
    logic [1:0]  data_m_bytesel;

    modport master (
        output data_m_addr,
        output data_m_data_out,
        output data_m_access,
        output data_m_wr_en,
        output data_m_bytesel,
        input  data_m_ack
    );

    modport slave (
        input  data_m_addr,
        input  data_m_data_out,
        input  data_m_access,
        input  data_m_wr_en,
        input  data_m_bytesel,
        output data_m_ack
    );
endinterface

// File: rtl/bus_stream_writer.sv
// -----------------------------------------------------------------------------
// bus_stream_writer
//   Turns a byte stream into aligned 16-bit data_m write transactions, for
//   bootloader / host-side memory fill without CPU involvement.
//
//   clk, reset        system clock, asynchronous active-high reset
//   start             one-cycle command strobe, honoured only when idle
//   start_addr[19:0]  first byte address
//   length[15:0]      byte count (0 completes immediately with done)
//   in_valid/in_data  byte stream; a byte moves when in_valid & in_ready
//   in_ready          high only while collecting bytes
//   bus               data_m initiator side (see bus_stream_writer_if)
//   busy              transfer in progress
//   done / error      one-cycle pulse on completion / ack timeout
//
//   ACK_TIMEOUT       cycles to wait for data_m_ack before aborting; 0 = never
// -----------------------------------------------------------------------------
module bus_stream_writer #(
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [19:0]                start_addr,
    input  logic [15:0]                length,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    output logic                       in_ready,
    bus_stream_writer_if.master        bus,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_GAP
    } state_t;

    state_t        r_state;
    logic [19:0]   r_addr;        // next byte address
    logic [15:0]   r_remaining;   // bytes still to accept
    logic [15:0]   r_data;
    logic [1:0]    r_bsel;
    logic [18:0]   r_bus_addr;
    logic          r_access;
    logic          r_in_ready;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic [TW-1:0] r_tmo;

    // The lane is picked by the byte's own address, so an odd start address
    // naturally produces a lone high-byte write.
    logic w_lane_hi;
    logic w_last_byte;
    logic w_expire;

    assign w_lane_hi   = r_addr[0];
    assign w_last_byte = (r_remaining == 16'd1);
    assign w_expire    = (ACK_TIMEOUT != 0) && (r_tmo == TW'(ACK_TIMEOUT - 1));

    assign in_ready            = r_in_ready;
    assign busy                = r_busy;
    assign done                = r_done;
    assign error               = r_error;
    assign bus.data_m_addr     = r_bus_addr;
    assign bus.data_m_data_out = r_data;
    assign bus.data_m_access   = r_access;
    assign bus.data_m_wr_en    = r_access;   // this initiator only writes
    assign bus.data_m_bytesel  = r_bsel;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values; blocking assignments would make the result
    // depend on statement order and mismatch between simulation and gates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_data      <= '0;
            r_bsel      <= '0;
            r_bus_addr  <= '0;
            r_access    <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_tmo       <= '0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= start_addr;
                        r_remaining <= length;
                        if (length == 16'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state    <= S_COLLECT;
                            r_busy     <= 1'b1;
                            r_in_ready <= 1'b1;
                        end
                    end
                end

                S_COLLECT: begin
                    if (in_valid) begin
                        if (w_lane_hi) begin
                            r_data[15:8] <= in_data;
                            r_bsel[1]    <= 1'b1;
                        end else begin
                            r_data[7:0]  <= in_data;
                            r_bsel[0]    <= 1'b1;
                        end
                        r_addr      <= r_addr + 20'd1;
                        r_remaining <= r_remaining - 16'd1;
                        // Halfword is complete when the high lane fills or the
                        // stream ends; both bytes share r_addr[19:1].
                        if (w_lane_hi || w_last_byte) begin
                            r_state    <= S_WRITE;
                            r_in_ready <= 1'b0;
                            r_access   <= 1'b1;
                            r_bus_addr <= r_addr[19:1];
                            r_tmo      <= '0;
                        end
                    end
                end

                S_WRITE: begin
                    // An ack arriving on the expiry cycle still counts as success.
                    if (bus.data_m_ack) begin
                        r_access <= 1'b0;
                        r_data   <= '0;
                        r_bsel   <= '0;
                        if (r_remaining == 16'd0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end else if (w_expire) begin
                        r_access <= 1'b0;
                        r_data   <= '0;
                        r_bsel   <= '0;
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_error  <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                S_GAP: begin
                    r_state    <= S_COLLECT;
                    r_in_ready <= 1'b1;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_stream_writer.sv
module tb_bus_stream_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [19:0] start_addr;
    logic [15:0] length;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        error;

    bus_stream_writer_if bus ();

    bus_stream_writer #(.ACK_TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .bus        (bus.master),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] a;
        logic [15:0] d;
        logic [1:0]  b;
        logic        w;
    } tx_t;

    tx_t txq[$];
    int  access_cycles = 0;
    int  busy_seen     = 0;
    int  done_count    = 0;
    int  error_count   = 0;
    bit  ack_en        = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Responder + monitor: samples 2 time units after each rising edge,
    // records each transaction on its first request cycle and acks it.
    initial begin
        bus.data_m_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.data_m_access) access_cycles++;
            if (busy)  busy_seen++;
            if (done)  done_count++;
            if (error) error_count++;
            if (ack_en && bus.data_m_access && !bus.data_m_ack) begin
                txq.push_back('{a: bus.data_m_addr, d: bus.data_m_data_out,
                                b: bus.data_m_bytesel, w: bus.data_m_wr_en});
                bus.data_m_ack = 1'b1;
            end else begin
                bus.data_m_ack = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [19:0] a, input logic [15:0] l);
        start      = 1'b1;
        start_addr = a;
        length     = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk({tag, " accept"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n  = 0;
        int d0 = done_count;
        int e0 = error_count;
        while (done_count == d0 && error_count == e0 && n < 100) begin
            tick();
            n++;
        end
        chk({tag, " finished"}, (n < 100), 1'b1);
        tick();
    endtask

    task automatic check_tx(input string tag, input int idx, input logic [18:0] a,
                            input logic [15:0] d, input logic [1:0] b);
        chk({tag, " present"}, (txq.size() > idx), 1'b1);
        if (txq.size() > idx) begin
            chk({tag, " addr"},   txq[idx].a, a);
            chk({tag, " data"},   txq[idx].d, d);
            chk({tag, " bsel"},   txq[idx].b, b);
            chk({tag, " wr_en"},  txq[idx].w, 1'b1);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " in_ready"}, in_ready, 1'b0);
        chk({tag, " busy"},     busy, 1'b0);
        chk({tag, " done"},     done, 1'b0);
        chk({tag, " error"},    error, 1'b0);
        chk({tag, " access"},   bus.data_m_access, 1'b0);
        chk({tag, " wr_en"},    bus.data_m_wr_en, 1'b0);
        chk({tag, " bsel"},     bus.data_m_bytesel, 2'b00);
        chk({tag, " addr"},     bus.data_m_addr, 19'h0);
        chk({tag, " dout"},     bus.data_m_data_out, 16'h0);
    endtask

    initial begin
        int q0, d0, e0, a0, b0;

        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // 1. Aligned, four bytes
        q0 = txq.size(); d0 = done_count; a0 = access_cycles;
        do_start(20'h01000, 16'd4);
        chk("t1 busy after start", busy, 1'b1);
        chk("t1 in_ready after start", in_ready, 1'b1);
        send_byte("t1 b0", 8'h11);
        send_byte("t1 b1", 8'h22);
        send_byte("t1 b2", 8'h33);
        send_byte("t1 b3", 8'h44);
        wait_end("t1");
        chk("t1 tx count", txq.size() - q0, 2);
        check_tx("t1 tx0", q0,     19'h00800, 16'h2211, 2'b11);
        check_tx("t1 tx1", q0 + 1, 19'h00801, 16'h4433, 2'b11);
        chk("t1 done count", done_count - d0, 1);
        chk("t1 access cycles", access_cycles - a0, 2);
        chk("t1 busy low", busy, 1'b0);

        // 2. Unaligned start, odd length
        q0 = txq.size(); d0 = done_count;
        do_start(20'h00003, 16'd3);
        send_byte("t2 b0", 8'hAA);
        send_byte("t2 b1", 8'hBB);
        send_byte("t2 b2", 8'hCC);
        wait_end("t2");
        chk("t2 tx count", txq.size() - q0, 2);
        check_tx("t2 tx0", q0,     19'h00001, 16'hAA00, 2'b10);
        check_tx("t2 tx1", q0 + 1, 19'h00002, 16'hCCBB, 2'b11);
        chk("t2 done count", done_count - d0, 1);

        // 3. Single final byte at even address
        q0 = txq.size(); d0 = done_count;
        do_start(20'h00010, 16'd1);
        send_byte("t3 b0", 8'h5A);
        wait_end("t3");
        chk("t3 tx count", txq.size() - q0, 1);
        check_tx("t3 tx0", q0, 19'h00008, 16'h005A, 2'b01);
        chk("t3 done count", done_count - d0, 1);
        chk("t3 in_ready low", in_ready, 1'b0);
        chk("t3 busy low", busy, 1'b0);

        // 4. Zero length
        a0 = access_cycles; b0 = busy_seen; d0 = done_count;
        do_start(20'h00400, 16'd0);
        chk("t4 done next cycle", done, 1'b1);
        chk("t4 busy", busy, 1'b0);
        tick();
        chk("t4 done pulse ends", done, 1'b0);
        tick();
        chk("t4 done count", done_count - d0, 1);
        chk("t4 no access", access_cycles - a0, 0);
        chk("t4 no busy", busy_seen - b0, 0);

        // 5. Address wrap
        q0 = txq.size();
        do_start(20'hFFFFF, 16'd2);
        send_byte("t5 b0", 8'h01);
        send_byte("t5 b1", 8'h02);
        wait_end("t5");
        chk("t5 tx count", txq.size() - q0, 2);
        check_tx("t5 tx0", q0,     19'h7FFFF, 16'h0100, 2'b10);
        check_tx("t5 tx1", q0 + 1, 19'h00000, 16'h0002, 2'b01);

        // 6a. Ack timeout
        ack_en = 1'b0;
        a0 = access_cycles; d0 = done_count; e0 = error_count;
        do_start(20'h00020, 16'd2);
        send_byte("t6 b0", 8'h77);
        send_byte("t6 b1", 8'h88);
        chk("t6 access held", bus.data_m_access, 1'b1);
        chk("t6 wr_en held", bus.data_m_wr_en, 1'b1);
        chk("t6 addr held", bus.data_m_addr, 19'h00010);
        chk("t6 data held", bus.data_m_data_out, 16'h8877);
        chk("t6 bsel held", bus.data_m_bytesel, 2'b11);
        wait_end("t6");
        chk("t6 access cycles", access_cycles - a0, 8);
        chk("t6 error count", error_count - e0, 1);
        chk("t6 no done", done_count - d0, 0);
        chk("t6 busy low", busy, 1'b0);
        chk("t6 access low", bus.data_m_access, 1'b0);

        // 6b. Reset during WRITE
        do_start(20'h00030, 16'd4);
        send_byte("t6r b0", 8'h9A);
        send_byte("t6r b1", 8'hBC);
        tick();
        chk("t6r access before reset", bus.data_m_access, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("t6r async");
        tick();
        reset  = 1'b0;
        ack_en = 1'b1;
        a0 = access_cycles; q0 = txq.size();
        in_valid = 1'b1;
        in_data  = 8'hEE;
        repeat (5) tick();
        in_valid = 1'b0;
        chk("t6r no access after reset", access_cycles - a0, 0);
        chk("t6r no tx after reset", txq.size() - q0, 0);
        chk("t6r in_ready stays low", in_ready, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
